// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, stop-bit check,
// and a valid/ack byte handshake with sticky overrun and a one-cycle framing-error pulse.
module uart_rx #(
  parameter int CLOCK_HZ     = 1_000_000,
  parameter int BAUD_HZ      = 9_600,
  parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD_HZ,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             busy_q;

  logic rxs;
  logic bit_tc;
  logic half_tc;
  logic good_frame;

  assign rxs        = sync_q[1];
  assign bit_tc     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_tc    = (cnt_q == CNT_W'(HALF_BIT - 1));
  assign good_frame = (state_q == STOP) && bit_tc && rxs;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], serial_rx};
      frame_err_q <= 1'b0;

      // A store on the same edge as an ack wins: valid stays set, overrun untouched.
      if (good_frame) begin
        rx_byte_q  <= shift_q;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !rx_ack) overrun_q <= 1'b1;
      end else if (rx_ack) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (half_tc) begin
            cnt_q <= '0;
            if (!rxs) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_tc) begin
            cnt_q     <= '0;
            shift_q   <= {rxs, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_tc) begin
            cnt_q <= '0;
            if (rxs) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= WAIT_IDLE;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line releases so a break cannot re-trigger.
          if (rxs) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, single frame latency, glitch rejection,
// framing error, overrun, and reset mid-frame.
module tb_uart_rx;

  localparam int CPB  = 104;
  localparam int HALF = 52;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;

  uart_rx dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .serial_rx (serial_rx),
    .rx_ack    (rx_ack),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (rx_valid && !valid_prev && rise_cyc < 0) rise_cyc = cyc;
    valid_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Callers sit at posedge+1; each returns at posedge+1.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_rx = b;
    clocks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    clocks(1);
    rx_ack = 1'b0;
  endtask

  int c0;

  initial begin
    // Reset with the line toggling
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      serial_rx = i[0];
      clocks(1);
    end
    @(negedge clk);
    chk("rst_byte", {24'd0, rx_byte}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    serial_rx = 1'b1;
    reset_n = 1'b1;
    clocks(10);
    @(negedge clk);
    chk("post_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Single frame 0xA5, latency from first low-sampling edge to rx_valid
    c0 = cyc;
    rise_cyc = -1;
    fe_cnt = 0;
    send_frame(8'hA5, 1'b1);
    clocks(5);
    chk("a5_latency", rise_cyc - (c0 + 1), 32'd990);
    chk("a5_byte", {24'd0, rx_byte}, 32'hA5);
    chk("a5_valid", {31'd0, rx_valid}, 32'd1);
    chk("a5_ferr", fe_cnt, 32'd0);
    ack_pulse();
    @(negedge clk);
    chk("a5_ack_valid", {31'd0, rx_valid}, 32'd0);
    chk("a5_ack_byte", {24'd0, rx_byte}, 32'hA5);
    @(posedge clk); #1;

    // Glitch: 20 clocks low
    c0 = cyc;
    fe_cnt = 0;
    serial_rx = 1'b0;
    clocks(20);
    serial_rx = 1'b1;
    while (cyc < c0 + 1 + HALF + 2) @(negedge clk);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    clocks(CPB);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_ferr", fe_cnt, 32'd0);

    // Glitch: busy must have been high during the low window
    c0 = cyc;
    serial_rx = 1'b0;
    clocks(10);
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    clocks(10);
    serial_rx = 1'b1;
    clocks(HALF + 10);
    chk("glitch2_busy_end", {31'd0, busy}, 32'd0);

    // Framing error on 0x3C, line then held low
    fe_cnt = 0;
    send_frame(8'h3C, 1'b0);
    serial_rx = 1'b0;
    clocks(300);
    chk("fe_pulse_count", fe_cnt, 32'd1);
    chk("fe_valid", {31'd0, rx_valid}, 32'd0);
    chk("fe_busy_held", {31'd0, busy}, 32'd1);
    chk("fe_byte_kept", {24'd0, rx_byte}, 32'hA5);
    serial_rx = 1'b1;
    clocks(5);
    chk("fe_busy_release", {31'd0, busy}, 32'd0);
    clocks(CPB);
    send_frame(8'h81, 1'b1);
    clocks(5);
    chk("after_fe_byte", {24'd0, rx_byte}, 32'h81);
    chk("after_fe_valid", {31'd0, rx_valid}, 32'd1);
    ack_pulse();
    clocks(2);

    // Overrun: back-to-back frames without ack
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    clocks(5);
    chk("ovr_byte", {24'd0, rx_byte}, 32'h22);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    ack_pulse();
    @(negedge clk);
    chk("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
    chk("ovr_ack_flag", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    clocks(CPB);

    // Reset during data bit 4 of 0xFF
    fe_cnt = 0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    serial_rx = 1'b1;
    clocks(CPB / 2);
    reset_n = 1'b0;
    clocks(3);
    chk("midrst_byte", {24'd0, rx_byte}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    clocks(2 * CPB);
    send_frame(8'h5A, 1'b1);
    clocks(5);
    chk("midrst_new_byte", {24'd0, rx_byte}, 32'h5A);
    chk("midrst_valid", {31'd0, rx_valid}, 32'd1);
    chk("midrst_ferr", fe_cnt, 32'd0);
    chk("midrst_ovr", {31'd0, overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the board's 8N1 serial link; pairs with the existing transmit shift-register UART.
- Oversamples `serial_rx` with the system clock and detects the start bit.
- Samples each data bit at mid-bit, checks the stop bit, then presents the byte with a valid/ack handshake.
- Sits between the external RX pin and the command/byte consumer logic.

Parameters:
- CLOCK_HZ, 1_000_000, system clock frequency.
- BAUD_HZ, 9_600, line bit rate.
- CLKS_PER_BIT, CLOCK_HZ/BAUD_HZ (104), clocks per bit period; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (52), clocks from start-edge detection to the start-bit centre.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- serial_rx  in  1  asynchronous serial line; idle high, LSB-first 8N1.
- rx_byte  out  8  last correctly framed byte; held until the next good frame.
- rx_valid  out  1  high while rx_byte is unconsumed.
- rx_ack  in  1  consumer accepts rx_byte; clears rx_valid next edge.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- overrun  out  1  sticky; set when a good frame completes while rx_valid is already 1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Synchronizer: 2-flop chain on serial_rx. Flops reset to 1. All logic uses the second flop, called `rxs`.
- Reset values (reset_n low at an edge): rx_byte=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, bit counter=0, clock counter=0.
- Reset mid-frame aborts the frame with no output change other than the reset values above.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rxs==0, go to START and clear the clock counter.
- START: the counter counts up each cycle.
  - At count==HALF_BIT-1, test rxs.
  - rxs==0: go to DATA, clear counter and bit index.
  - rxs==1: glitch; return to IDLE with no flags.
- DATA: at count==CLKS_PER_BIT-1, sample rxs into shift[7] (shift right, LSB arrives first) and clear the counter.
  - After the 8th sample, go to STOP.
- STOP: at count==CLKS_PER_BIT-1, test rxs.
  - rxs==1 (good frame): rx_byte<=shift, rx_valid<=1. If rx_valid was already 1 and rx_ack is not 1 on that edge, overrun<=1 and rx_byte is still overwritten. Go to IDLE.
  - rxs==0 (framing error): frame_err<=1 for exactly one cycle. rx_byte and rx_valid are unchanged. Go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs==1, then go to IDLE. This stops a break condition from re-triggering continuously.
- Latency: the good-frame edge comes HALF_BIT + 9*CLKS_PER_BIT clocks after the IDLE->START edge. With defaults that is 52+936=988 clocks.
- The IDLE->START edge comes 2 clocks (synchronizer) after the first edge at which serial_rx is low.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - rx_ack on the same edge as a good-frame store: the store wins, rx_valid stays 1, and no overrun is flagged.
- overrun clears only on an edge where rx_ack=1 and no new store occurs, or on reset.
- After a good frame, returning to IDLE mid-stop-bit allows back-to-back frames with no idle gap.
- Counters: clock counter is ceil(log2(CLKS_PER_BIT)) bits; bit index is 3 bits. No wrap is possible because counters are cleared at each terminal count.

Test Plan:
- Reset: hold reset_n=0 for 5 clocks with serial_rx toggling -> all outputs 0 and busy=0; release with serial_rx=1 -> outputs stay 0.
- Single frame 0xA5 at 104 clocks/bit -> rx_valid rises 990 clocks after the falling edge of serial_rx, rx_byte=0xA5, frame_err=0; pulse rx_ack -> rx_valid=0 next edge, rx_byte stays 0xA5.
- Glitch: serial_rx low for 20 clocks then high -> busy goes high then returns to 0 within HALF_BIT+3 clocks; no rx_valid, no frame_err.
- Framing error: send 0x3C with the stop bit driven low, hold the line low 300 more clocks, then high -> one-cycle frame_err, rx_valid stays 0, busy stays high until the line returns high; then send 0x81 -> rx_byte=0x81.
- Overrun: send 0x11 then back-to-back 0x22 with no rx_ack -> rx_byte=0x22, rx_valid=1, overrun=1; rx_ack -> rx_valid=0, overrun=0.
- Reset mid-frame: assert reset_n=0 during data bit 4 of 0xFF, release, send 0x5A -> rx_byte=0x5A; no frame_err or overrun.
